// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcodes, control-word layout, FSM encoding and the combinational decoder.
package pipe_ctrl_pkg;
  localparam int CW = 11;
  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;
  localparam int B_REGWRITE = 0;
  localparam int B_ALUSRC   = 1;
  localparam int B_BRANCH   = 2;
  localparam int B_JP       = 3;
  localparam int B_JR       = 4;
  localparam int B_JAL      = 5;
  localparam int B_MEMREAD  = 6;
  localparam int B_MEMWRITE = 7;
  localparam int B_MEMTOREG = 8;
  localparam int B_BEX      = 9;
  localparam int B_SETX     = 10;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} md_state_e;
  function automatic logic [CW-1:0] decode(input logic [4:0] op);
    logic [CW-1:0] w;
    w = '0;
    w[B_REGWRITE] = op == OP_R || op == OP_ADDI || op == OP_JAL || op == OP_LW || op == OP_SETX;
    w[B_ALUSRC]   = op == OP_BNE || op == OP_ADDI || op == OP_SW || op == OP_LW || op == OP_JAL || op == OP_SETX;
    w[B_BRANCH]   = op == OP_BNE || op == OP_BLT;
    w[B_JP]       = op == OP_J;
    w[B_JR]       = op == OP_JR;
    w[B_JAL]      = op == OP_JAL;
    w[B_MEMREAD]  = op == OP_LW;
    w[B_MEMWRITE] = op == OP_SW;
    w[B_MEMTOREG] = op == OP_LW;
    w[B_BEX]      = op == OP_BEX;
    w[B_SETX]     = op == OP_SETX;
    return w;
  endfunction
  function automatic logic is_md(input logic [4:0] op, input logic [4:0] alu);
    return op == OP_R && (alu == ALU_MUL || alu == ALU_DIV);
  endfunction
endpackage

// File: rtl/pipe_ctrl_unit_md_seq.sv
// md_seq: mul/div occupancy FSM; BUSY for MD_CYCLES-1 cycles then one DONE cycle.
module md_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic accept_md,
  input  logic flush,
  output logic busy,
  output logic done,
  output logic md_start
);
  localparam int CNTW = $clog2(MD_CYCLES);
  md_state_e state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic md_start_q, md_start_d;
  always_comb begin
    state_d = IDLE;
    cnt_d = cnt_q;
    md_start_d = accept_md;
    if (flush) begin
      cnt_d = '0;
    end else if (accept_md) begin
      state_d = BUSY;
      cnt_d = CNTW'(MD_CYCLES - 2);
    end else if (state_q == BUSY) begin
      state_d = cnt_q == '0 ? DONE : BUSY;
      cnt_d = cnt_q == '0 ? '0 : cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      md_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      md_start_q <= md_start_d;
    end
  end
  assign busy = state_q == BUSY;
  assign done = state_q == DONE;
  assign md_start = md_start_q;
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: decodes the Decode-stage instruction and carries its control word
// through NUM_STAGES registers, freezing the front end while a mul/div owns Execute.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int MD_CYCLES  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [4:0]               opcode,
  input  logic [4:0]               alu_op,
  input  logic                     stall,
  input  logic                     flush,
  output logic [NUM_STAGES*CW-1:0] ctrl_pipe,
  output logic                     dec_stall,
  output logic                     md_start,
  output logic                     md_ready
);
  logic busy, done, accept_md;
  logic [CW-1:0] stage [NUM_STAGES];
  assign accept_md = in_valid & ~flush & ~stall & ~busy & is_md(opcode, alu_op);
  assign dec_stall = stall | busy;
  assign md_ready = done & ~flush;
  md_seq #(.MD_CYCLES(MD_CYCLES)) u_md_seq (
    .clock(clock),
    .reset(reset),
    .accept_md(accept_md),
    .flush(flush),
    .busy(busy),
    .done(done),
    .md_start(md_start)
  );
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_st
    logic [CW-1:0] stage_q, stage_d;
    if (k == 0) begin : g_x
      always_comb stage_d = flush ? '0 : (stall | busy) ? stage_q : in_valid ? decode(opcode) : '0;
    end else if (k == 1) begin : g_m
      // a held stage 0 must not be duplicated downstream, so stage 1 takes a bubble
      always_comb stage_d = (stall | busy) ? '0 : stage[0];
    end else begin : g_w
      always_comb stage_d = stage[k-1];
    end
    always_ff @(posedge clock or posedge reset) begin
      if (reset) stage_q <= '0;
      else stage_q <= stage_d;
    end
    assign stage[k] = stage_q;
    assign ctrl_pipe[k*CW +: CW] = stage_q;
  end
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: scenario tasks with a queue of expected control words per instruction.
module tb_pipe_ctrl_unit;
  localparam logic [4:0] LW = 5'b01000, SW = 5'b00111, ADDI = 5'b00101, RR = 5'b00000;
  localparam logic [4:0] BNE = 5'b00010, SETX = 5'b10101, MUL = 5'b00110, DIV = 5'b00111;
  localparam logic [10:0] W_LW = 11'h143, W_SW = 11'h082, W_ADDI = 11'h003, W_R = 11'h001;
  localparam logic [10:0] W_SETX = 11'h403;
  logic clock = 0, reset = 1, in_valid = 0, stall = 0, flush = 0;
  logic [4:0] opcode = 0, alu_op = 0;
  logic [32:0] ctrl_pipe;
  logic dec_stall, md_start, md_ready;
  int checks = 0, errors = 0;
  logic [10:0] exp_q[$];
  pipe_ctrl_unit #(.NUM_STAGES(3), .MD_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .opcode(opcode), .alu_op(alu_op),
    .stall(stall), .flush(flush), .ctrl_pipe(ctrl_pipe), .dec_stall(dec_stall),
    .md_start(md_start), .md_ready(md_ready)
  );
  always #5 clock = ~clock;
  function automatic logic [10:0] st(input int k);
    return ctrl_pipe[k*11 +: 11];
  endfunction
  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] al, input logic s, input logic f);
    in_valid = v; opcode = op; alu_op = al; stall = s; flush = f;
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset;
    drive(1, LW, 0, 0, 0);
    tick; reset = 0;
    tick; tick;
    checks++; if (st(0) !== W_LW) begin errors++; $display("FAIL pre_reset_st0 got %h exp %h", st(0), W_LW); end
    #2 reset = 1; #1;
    checks++; if (ctrl_pipe !== '0) begin errors++; $display("FAIL reset_pipe got %h exp 0", ctrl_pipe); end
    checks++; if ({dec_stall, md_start, md_ready} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {dec_stall, md_start, md_ready}); end
    drive(0, 0, 0, 0, 0);
    tick; reset = 0;
  endtask
  task automatic test_stream;
    logic [4:0] ops [4] = '{LW, SW, ADDI, RR};
    logic [10:0] ws [4] = '{W_LW, W_SW, W_ADDI, W_R};
    logic [10:0] e;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1, ops[i], 0, 0, 0); else drive(0, 0, 0, 0, 0);
      tick;
      exp_q.push_back(i < 4 ? ws[i] : 11'h0);
      checks++; if (st(0) !== exp_q[$]) begin errors++; $display("FAIL stream_st0[%0d] got %h exp %h", i, st(0), exp_q[$]); end
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        checks++; if (st(2) !== e) begin errors++; $display("FAIL stream_st2[%0d] got %h exp %h", i, st(2), e); end
      end
    end
    exp_q.delete();
  endtask
  task automatic test_flush;
    drive(1, BNE, 0, 0, 1);
    tick;
    checks++; if (st(0) !== 11'h0) begin errors++; $display("FAIL flush_st0 got %h exp 0", st(0)); end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({ctrl_pipe[24], ctrl_pipe[13], ctrl_pipe[2]} !== 3'b000) begin errors++; $display("FAIL flush_branch[%0d] got %b exp 000", i, {ctrl_pipe[24], ctrl_pipe[13], ctrl_pipe[2]}); end
      tick;
    end
    checks++; if (ctrl_pipe !== '0) begin errors++; $display("FAIL flush_pipe got %h exp 0", ctrl_pipe); end
  endtask
  task automatic test_mul;
    int ds = 0, ms = 0, rd = 0, hold = 0;
    logic [10:0] e;
    drive(1, RR, MUL, 0, 0);
    #1;
    checks++; if (dec_stall !== 1'b0) begin errors++; $display("FAIL mul_pre_stall got %b exp 0", dec_stall); end
    tick;
    exp_q.push_back(W_R);
    drive(1, ADDI, 0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      ds += dec_stall; ms += md_start; rd += md_ready; hold += int'(st(0) === W_R);
      if (c == 1) begin checks++; if (md_start !== 1'b1) begin errors++; $display("FAIL mul_start got %b exp 1", md_start); end end
      if (c == 4) begin checks++; if ({md_ready, dec_stall} !== 2'b10) begin errors++; $display("FAIL mul_done got %b exp 10", {md_ready, dec_stall}); end end
      if (c >= 2) begin checks++; if (st(1) !== 11'h0) begin errors++; $display("FAIL mul_bubble[%0d] got %h exp 0", c, st(1)); end end
      tick;
    end
    e = exp_q.pop_front();
    checks++; if (st(1) !== e) begin errors++; $display("FAIL mul_st1 got %h exp %h", st(1), e); end
    checks++; if (st(0) !== W_ADDI) begin errors++; $display("FAIL mul_next_st0 got %h exp %h", st(0), W_ADDI); end
    checks++; if (ds !== 3) begin errors++; $display("FAIL mul_stall_cycles got %0d exp 3", ds); end
    checks++; if (ms !== 1 || rd !== 1) begin errors++; $display("FAIL mul_pulses got %0d/%0d exp 1/1", ms, rd); end
    checks++; if (hold !== 4) begin errors++; $display("FAIL mul_hold got %0d exp 4", hold); end
    drive(0, 0, 0, 0, 0);
    tick;
  endtask
  task automatic test_md_flush;
    int rd = 0;
    drive(1, RR, DIV, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0);
    checks++; if (dec_stall !== 1'b1) begin errors++; $display("FAIL div_busy got %b exp 1", dec_stall); end
    tick;
    drive(0, 0, 0, 0, 1);
    tick;
    drive(0, 0, 0, 0, 0);
    checks++; if ({dec_stall, md_ready} !== 2'b00) begin errors++; $display("FAIL div_flush_flags got %b exp 00", {dec_stall, md_ready}); end
    checks++; if (st(0) !== 11'h0) begin errors++; $display("FAIL div_flush_st0 got %h exp 0", st(0)); end
    for (int i = 0; i < 4; i++) begin rd += md_ready + dec_stall; tick; end
    checks++; if (rd !== 0) begin errors++; $display("FAIL div_flush_quiet got %0d exp 0", rd); end
  endtask
  task automatic test_back_to_back;
    int ms = 0, rd = 0;
    logic [10:0] e;
    drive(1, RR, MUL, 0, 0);
    tick;
    exp_q.push_back(W_R);
    drive(1, RR, DIV, 0, 0);
    for (int c = 1; c <= 8; c++) begin
      ms += md_start; rd += md_ready;
      if (c == 4) begin checks++; if ({md_ready, dec_stall} !== 2'b10) begin errors++; $display("FAIL b2b_done got %b exp 10", {md_ready, dec_stall}); end end
      if (c == 5) begin
        checks++; if ({md_start, dec_stall} !== 2'b11) begin errors++; $display("FAIL b2b_rebusy got %b exp 11", {md_start, dec_stall}); end
        e = exp_q.pop_front();
        checks++; if (st(1) !== e) begin errors++; $display("FAIL b2b_mul_st1 got %h exp %h", st(1), e); end
      end
      tick;
      if (c == 4) begin drive(0, 0, 0, 0, 0); exp_q.push_back(W_R); end
    end
    e = exp_q.pop_front();
    checks++; if (st(1) !== e) begin errors++; $display("FAIL b2b_div_st1 got %h exp %h", st(1), e); end
    checks++; if (ms !== 2 || rd !== 2) begin errors++; $display("FAIL b2b_pulses got %0d/%0d exp 2/2", ms, rd); end
    checks++; if ({dec_stall, md_ready} !== 2'b00) begin errors++; $display("FAIL b2b_idle got %b exp 00", {dec_stall, md_ready}); end
  endtask
  task automatic test_stall_flush;
    drive(1, ADDI, 0, 0, 0);
    tick;
    drive(1, SETX, 0, 1, 1);
    #1;
    checks++; if (dec_stall !== 1'b1) begin errors++; $display("FAIL sf_dec_stall got %b exp 1", dec_stall); end
    tick;
    checks++; if ({st(1), st(0)} !== 22'h0) begin errors++; $display("FAIL sf_bubble got %h/%h exp 0/0", st(1), st(0)); end
    checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL sf_md_start got %b exp 0", md_start); end
    drive(1, SETX, 0, 0, 0);
    #1;
    checks++; if (dec_stall !== 1'b0) begin errors++; $display("FAIL sf_idle got %b exp 0", dec_stall); end
    tick;
    checks++; if (st(0) !== W_SETX) begin errors++; $display("FAIL setx_st0 got %h exp %h", st(0), W_SETX); end
    drive(1, LW, 0, 1, 0);
    tick;
    checks++; if (st(0) !== W_SETX || st(1) !== 11'h0) begin errors++; $display("FAIL stall_hold got %h/%h exp %h/0", st(0), st(1), W_SETX); end
    drive(0, 0, 0, 0, 0);
    tick;
  endtask
  task automatic test_reset_busy;
    int rd = 0;
    drive(1, RR, MUL, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0);
    tick;
    checks++; if (dec_stall !== 1'b1) begin errors++; $display("FAIL rb_busy got %b exp 1", dec_stall); end
    #2 reset = 1; #1;
    checks++; if ({ctrl_pipe, dec_stall, md_start} !== 35'h0) begin errors++; $display("FAIL rb_clear got %h/%b/%b exp 0", ctrl_pipe, dec_stall, md_start); end
    tick; reset = 0;
    for (int i = 0; i < 6; i++) begin rd += md_ready + dec_stall; tick; end
    checks++; if (rd !== 0) begin errors++; $display("FAIL rb_no_ready got %0d exp 0", rd); end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_stream;
    test_flush;
    test_mul;
    test_md_flush;
    test_back_to_back;
    test_stall_flush;
    test_reset_busy;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
